posit_fpu_issuer: RTL and testbench

POSIT_FPU_ISSUER -- requirements
Module: posit_fpu_issuer

---
 rtl/posit_fpu_issuer.sv | 199 +++++++++++++++++++
 tb/tb_posit_fpu_issuer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_fpu_issuer.sv
// rtl/posit_fpu_issuer.sv - request FIFO, operation rewrite and in-order issue/return for a posit FMA unit
module posit_fpu_issuer #(
    parameter int N       = 16,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 4,
    parameter int TAG_W   = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [3*N-1:0]   req_operands_i,
    input  logic [1:0]       req_op_i,
    input  logic             req_op_mod_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             fma_valid_o,
    input  logic             fma_ready_i,
    output logic [3*N-1:0]   fma_operands_o,
    output logic [1:0]       fma_op_o,
    output logic             fma_op_mod_o,
    output logic [TAG_W-1:0] fma_tag_o,
    output logic             fma_flush_o,
    input  logic             fma_out_valid_i,
    output logic             fma_out_ready_o,
    input  logic [N-1:0]     fma_result_i,
    input  logic [4:0]       fma_status_i,
    input  logic [TAG_W-1:0] fma_tag_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [N-1:0]     rsp_result_o,
    output logic [4:0]       rsp_status_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    input  logic             flush_i,
    output logic             busy_o
);
    localparam int PW  = $clog2(DEPTH);
    localparam int FCW = $clog2(DEPTH + 1);
    localparam int CW  = $clog2(MAX_OUT + 1);
    localparam int EW  = 3*N + 3 + TAG_W;

    localparam logic [1:0]     OP_FMADD  = 2'd0;
    localparam logic [1:0]     OP_ADD    = 2'd2;
    localparam logic [1:0]     OP_MUL    = 2'd3;
    localparam logic [0:0]     ST_RUN    = 1'b0;
    localparam logic [0:0]     ST_DRAIN  = 1'b1;
    localparam logic [N-1:0]   POSIT_ONE = {2'b01, {(N-2){1'b0}}};
    localparam logic [FCW-1:0] FIFO_FULL = FCW'(DEPTH);
    localparam logic [CW-1:0]  OUT_MAX   = CW'(MAX_OUT);

    logic [0:0]     state, state_next;
    logic [EW-1:0]  fifo_mem [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [FCW-1:0] fifo_cnt;
    logic           iss_valid;
    logic [CW-1:0]  out_cnt, cnt_next;
    logic           req_xfer, iss_xfer, out_xfer, rsp_xfer;
    logic           fifo_empty, can_load, pop, bypass, push, dec_ok;
    logic [EW-1:0]  req_entry, src_entry;
    logic [3*N-1:0] src_ops, new_ops;
    logic [1:0]     src_op, new_op;
    logic           src_mod, new_mod;
    logic [TAG_W-1:0] src_tag;

    assign req_ready_o     = (fifo_cnt != FIFO_FULL) && (state == ST_RUN);
    assign req_xfer        = req_valid_i && req_ready_o;
    assign fma_valid_o     = iss_valid && (out_cnt != OUT_MAX);
    assign iss_xfer        = fma_valid_o && fma_ready_i;
    assign fma_out_ready_o = (state == ST_DRAIN) ? 1'b1 : (!rsp_valid_o || rsp_ready_i);
    assign out_xfer        = fma_out_valid_i && fma_out_ready_o;
    assign rsp_xfer        = rsp_valid_o && rsp_ready_i;
    assign dec_ok          = out_xfer && (out_cnt != '0);
    assign busy_o          = (fifo_cnt != '0) || iss_valid || rsp_valid_o ||
                             (out_cnt != '0) || (state == ST_DRAIN);

    // When the FIFO is empty a fresh request goes straight into the issue stage
    // so the FMA sees it one cycle after acceptance.
    assign req_entry  = {req_operands_i, req_op_i, req_op_mod_i, req_tag_i};
    assign fifo_empty = (fifo_cnt == '0);
    assign can_load   = (state == ST_RUN) && !flush_i && (!iss_valid || iss_xfer);
    assign pop        = can_load && !fifo_empty;
    assign bypass     = can_load && fifo_empty && req_xfer;
    assign push       = req_xfer && !bypass && !flush_i;
    assign src_entry  = fifo_empty ? req_entry : fifo_mem[rd_ptr];

    // Map ADD and MUL onto FMADD with a constant one or zero operand.
    always_comb begin
        src_ops = src_entry[EW-1 -: 3*N];
        src_op  = src_entry[TAG_W+1 +: 2];
        src_mod = src_entry[TAG_W];
        src_tag = src_entry[TAG_W-1:0];
        new_ops = src_ops;
        new_op  = src_op;
        new_mod = src_mod;
        case (src_op)
            OP_ADD: begin
                new_ops = {src_ops[2*N-1:0], POSIT_ONE};
                new_op  = OP_FMADD;
            end
            OP_MUL: begin
                new_ops = {{N{1'b0}}, src_ops[2*N-1:0]};
                new_op  = OP_FMADD;
                new_mod = 1'b0;
            end
            default: ;
        endcase
    end

    // Outstanding count: issue and return in the same cycle cancel out.
    always_comb begin
        cnt_next = out_cnt;
        if (iss_xfer && !dec_ok) begin
            cnt_next = out_cnt + CW'(1);
        end else if (!iss_xfer && dec_ok) begin
            cnt_next = out_cnt - CW'(1);
        end
    end

    // DRAIN swallows results of work discarded by a flush until none remain.
    always_comb begin
        state_next = state;
        if (state == ST_RUN) begin
            state_next = (flush_i && (cnt_next != '0)) ? ST_DRAIN : ST_RUN;
        end else begin
            state_next = (!flush_i && (cnt_next == '0)) ? ST_RUN : ST_DRAIN;
        end
    end

    // FIFO storage needs no reset; validity lives in the count and pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= req_entry;
        end
    end

    // Control state, FIFO pointers, counter and flush pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_RUN;
            out_cnt     <= '0;
            fma_flush_o <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
        end else begin
            state       <= state_next;
            out_cnt     <= cnt_next;
            fma_flush_o <= flush_i;
            if (flush_i) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                fifo_cnt <= fifo_cnt + FCW'(push) - FCW'(pop);
            end
        end
    end

    // Registered issue stage holding the rewritten operation.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            iss_valid      <= 1'b0;
            fma_operands_o <= '0;
            fma_op_o       <= '0;
            fma_op_mod_o   <= 1'b0;
            fma_tag_o      <= '0;
        end else if (flush_i || (state == ST_DRAIN)) begin
            iss_valid <= 1'b0;
        end else if (pop || bypass) begin
            iss_valid      <= 1'b1;
            fma_operands_o <= new_ops;
            fma_op_o       <= new_op;
            fma_op_mod_o   <= new_mod;
            fma_tag_o      <= src_tag;
        end else if (iss_xfer) begin
            iss_valid <= 1'b0;
        end
    end

    // Single response register; results arriving in DRAIN are dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_o  <= 1'b0;
            rsp_result_o <= '0;
            rsp_status_o <= '0;
            rsp_tag_o    <= '0;
        end else if (flush_i) begin
            rsp_valid_o <= 1'b0;
        end else if (out_xfer && (state == ST_RUN)) begin
            rsp_valid_o  <= 1'b1;
            rsp_result_o <= fma_result_i;
            rsp_status_o <= fma_status_i;
            rsp_tag_o    <= fma_tag_i;
        end else if (rsp_xfer) begin
            rsp_valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_posit_fpu_issuer.sv
// tb/tb_posit_fpu_issuer.sv - scoreboard bench for posit_fpu_issuer
module tb_posit_fpu_issuer;
    localparam int N = 16;
    localparam int TAG_W = 4;

    typedef struct packed {
        logic [3*N-1:0]   ops;
        logic [1:0]       op;
        logic             mod;
        logic [TAG_W-1:0] tag;
    } iss_t;

    typedef struct packed {
        logic [N-1:0]     res;
        logic [4:0]       st;
        logic [TAG_W-1:0] tag;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0, req_ready, req_mod = 1'b0;
    logic [3*N-1:0] req_operands = '0;
    logic [1:0] req_op = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic fma_valid, fma_ready = 1'b0, fma_op_mod, fma_flush;
    logic [3*N-1:0] fma_operands;
    logic [1:0] fma_op;
    logic [TAG_W-1:0] fma_tag, fma_rtag = '0;
    logic fma_out_valid = 1'b0, fma_out_ready;
    logic [N-1:0] fma_result = '0;
    logic [4:0] fma_status = '0;
    logic rsp_valid, rsp_ready = 1'b0;
    logic [N-1:0] rsp_result;
    logic [4:0] rsp_status;
    logic [TAG_W-1:0] rsp_tag;
    logic flush = 1'b0, busy;

    int checks = 0, errors = 0;
    int n_iss = 0, n_out = 0, n_rsp = 0, release_cnt = 0;
    logic req_fire = 1'b0, iss_fire = 1'b0, out_fire = 1'b0, rsp_fire = 1'b0;
    iss_t exp_iss[$];
    rsp_t exp_rsp[$];
    rsp_t model_q[$];
    iss_t mon_e, mon_g;
    rsp_t mon_r, mon_x;

    posit_fpu_issuer #(.N(N), .DEPTH(4), .MAX_OUT(4), .TAG_W(TAG_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_operands_i(req_operands), .req_op_i(req_op),
        .req_op_mod_i(req_mod), .req_tag_i(req_tag),
        .fma_valid_o(fma_valid), .fma_ready_i(fma_ready),
        .fma_operands_o(fma_operands), .fma_op_o(fma_op),
        .fma_op_mod_o(fma_op_mod), .fma_tag_o(fma_tag),
        .fma_flush_o(fma_flush),
        .fma_out_valid_i(fma_out_valid), .fma_out_ready_o(fma_out_ready),
        .fma_result_i(fma_result), .fma_status_i(fma_status), .fma_tag_i(fma_rtag),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result), .rsp_status_o(rsp_status), .rsp_tag_o(rsp_tag),
        .flush_i(flush), .busy_o(busy)
    );

    always #5 clk = ~clk;

    function automatic iss_t rewrite(input logic [3*N-1:0] ops, input logic [1:0] op,
                                     input logic mod, input logic [TAG_W-1:0] tag);
        iss_t r;
        logic [N-1:0] a, b;
        a = ops[N-1:0];
        b = ops[2*N-1:N];
        r.tag = tag;
        case (op)
            2'd2: begin r.ops = {b, a, 16'h4000}; r.op = 2'd0; r.mod = mod; end
            2'd3: begin r.ops = {16'h0000, b, a}; r.op = 2'd0; r.mod = 1'b0; end
            default: begin r.ops = ops; r.op = op; r.mod = mod; end
        endcase
        return r;
    endfunction

    // Transfers are observed mid-cycle, where inputs and outputs are stable.
    always @(negedge clk) begin
        req_fire = !rst && req_valid && req_ready;
        iss_fire = !rst && fma_valid && fma_ready;
        out_fire = !rst && fma_out_valid && fma_out_ready;
        rsp_fire = !rst && rsp_valid && rsp_ready;
        if (req_fire) exp_iss.push_back(rewrite(req_operands, req_op, req_mod, req_tag));
        if (iss_fire) begin
            n_iss++;
            checks++;
            mon_g = {fma_operands, fma_op, fma_op_mod, fma_tag};
            if (exp_iss.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected: got %h, none expected", mon_g);
            end else begin
                mon_e = exp_iss.pop_front();
                if (mon_g !== mon_e) begin
                    errors++;
                    $display("FAIL issue_payload: got %h, expected %h", mon_g, mon_e);
                end
            end
            mon_r.res = fma_operands[N-1:0] + fma_operands[2*N-1:N] + fma_operands[3*N-1:2*N];
            mon_r.st  = {fma_tag, 1'b1};
            mon_r.tag = fma_tag;
            model_q.push_back(mon_r);
            exp_rsp.push_back(mon_r);
        end
        if (out_fire) begin
            n_out++;
            if (model_q.size() > 0) void'(model_q.pop_front());
            if (release_cnt > 0) release_cnt--;
        end
        if (rsp_fire) begin
            n_rsp++;
            checks++;
            mon_x = {rsp_result, rsp_status, rsp_tag};
            if (exp_rsp.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got %h, none expected", mon_x);
            end else begin
                mon_r = exp_rsp.pop_front();
                if (mon_x !== mon_r) begin
                    errors++;
                    $display("FAIL rsp_payload: got %h, expected %h", mon_x, mon_r);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (!(fma_out_valid && !out_fire)) begin
            if (release_cnt > 0 && model_q.size() > 0) begin
                fma_out_valid = 1'b1;
                {fma_result, fma_status, fma_rtag} = model_q[0];
            end else begin
                fma_out_valid = 1'b0;
            end
        end
    endtask

    task automatic send_req(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [N-1:0] c, input logic mod, input logic [TAG_W-1:0] tag);
        int k = 0;
        req_valid = 1'b1; req_op = op; req_operands = {c, b, a}; req_mod = mod; req_tag = tag;
        do begin step(); k++; end while (!req_fire && k < 50);
        req_valid = 1'b0;
        checks++;
        if (!req_fire) begin errors++; $display("FAIL req_accept: tag %0d not accepted in %0d cycles", tag, k); end
    endtask

    task automatic wait_issues(input int target);
        int k = 0;
        while (n_iss < target && k < 100) begin step(); k++; end
        checks++;
        if (n_iss < target) begin errors++; $display("FAIL issue_timeout: got %0d issues, expected %0d", n_iss, target); end
    endtask

    task automatic wait_out(input int target);
        int k = 0;
        while (n_out < target && k < 100) begin step(); k++; end
        checks++;
        if (n_out < target) begin errors++; $display("FAIL result_timeout: got %0d results, expected %0d", n_out, target); end
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy || exp_rsp.size() != 0 || exp_iss.size() != 0) && k < 200) begin step(); k++; end
        checks++;
        if (busy || exp_rsp.size() != 0) begin
            errors++;
            $display("FAIL idle_timeout: busy=%0b, %0d responses still expected", busy, exp_rsp.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++;
        if ({fma_valid, fma_flush, rsp_valid, busy, fma_out_ready, req_ready} !== 6'b000011) begin
            errors++;
            $display("FAIL reset_ctl: got %b, expected 000011",
                     {fma_valid, fma_flush, rsp_valid, busy, fma_out_ready, req_ready});
        end
        checks++;
        if ({fma_operands, fma_op, fma_op_mod, fma_tag} !== '0) begin
            errors++; $display("FAIL reset_fma_payload: got %h, expected 0", {fma_operands, fma_op, fma_op_mod, fma_tag});
        end
        checks++;
        if ({rsp_result, rsp_status, rsp_tag} !== '0) begin
            errors++; $display("FAIL reset_rsp_payload: got %h, expected 0", {rsp_result, rsp_status, rsp_tag});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_add();
        fma_ready = 1'b0; rsp_ready = 1'b1; release_cnt = 0;
        send_req(2'd2, 16'h5000, 16'h5800, 16'h1234, 1'b0, 4'd3);
        checks++;
        if (fma_valid !== 1'b1) begin errors++; $display("FAIL add_latency: fma_valid=%b, expected 1", fma_valid); end
        checks++;
        if ({fma_operands, fma_op, fma_op_mod, fma_tag} !== {16'h5800, 16'h5000, 16'h4000, 2'd0, 1'b0, 4'd3}) begin
            errors++; $display("FAIL add_payload: got %h", {fma_operands, fma_op, fma_op_mod, fma_tag});
        end
        fma_ready = 1'b1; release_cnt = 100;
        wait_idle();
    endtask

    task automatic test_mul();
        fma_ready = 1'b0; release_cnt = 0;
        send_req(2'd3, 16'h5000, 16'h5800, 16'h7777, 1'b1, 4'd5);
        checks++;
        if ({fma_valid, fma_operands, fma_op, fma_op_mod, fma_tag} !== {1'b1, 16'h0000, 16'h5800, 16'h5000, 2'd0, 1'b0, 4'd5}) begin
            errors++; $display("FAIL mul_payload: got %h", {fma_valid, fma_operands, fma_op, fma_op_mod, fma_tag});
        end
        fma_ready = 1'b1; release_cnt = 100;
        wait_idle();
    endtask

    task automatic test_outstanding();
        int b_iss, b_out, b_rsp;
        fma_ready = 1'b1; release_cnt = 0; rsp_ready = 1'b1;
        b_iss = n_iss; b_out = n_out; b_rsp = n_rsp;
        for (int i = 0; i < 6; i++) begin
            send_req(2'(i % 4), 16'($urandom), 16'($urandom), 16'($urandom), 1'(i), 4'(8 + i));
        end
        repeat (4) step();
        checks++;
        if (n_iss - b_iss != 4) begin errors++; $display("FAIL max_out_issues: got %0d, expected 4", n_iss - b_iss); end
        checks++;
        if (fma_valid !== 1'b0) begin errors++; $display("FAIL max_out_suppress: fma_valid=%b, expected 0", fma_valid); end
        release_cnt = 1;
        wait_out(b_out + 1);
        repeat (3) step();
        checks++;
        if (n_iss - b_iss != 5 || fma_valid !== 1'b0) begin
            errors++; $display("FAIL max_out_refill: issues=%0d valid=%b, expected 5 and 0", n_iss - b_iss, fma_valid);
        end
        release_cnt = 1;
        wait_out(b_out + 2);
        repeat (3) step();
        checks++;
        if (n_iss - b_iss != 6) begin errors++; $display("FAIL max_out_last: got %0d issues, expected 6", n_iss - b_iss); end
        release_cnt = 100;
        wait_idle();
        checks++;
        if (n_rsp - b_rsp != 6) begin errors++; $display("FAIL max_out_rsps: got %0d responses, expected 6", n_rsp - b_rsp); end
    endtask

    task automatic test_backpressure();
        int k = 0, b_rsp;
        rsp_t held;
        fma_ready = 1'b1; rsp_ready = 1'b0; release_cnt = 100; b_rsp = n_rsp;
        send_req(2'd0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 4'd1);
        send_req(2'd1, 16'h4444, 16'h5555, 16'h6666, 1'b1, 4'd2);
        send_req(2'd2, 16'h0101, 16'h0202, 16'h0303, 1'b1, 4'd4);
        while (!rsp_valid && k < 50) begin step(); k++; end
        repeat (3) step();
        held = {rsp_result, rsp_status, rsp_tag};
        repeat (3) step();
        checks++;
        if (rsp_valid !== 1'b1 || {rsp_result, rsp_status, rsp_tag} !== held) begin
            errors++; $display("FAIL bp_hold: valid=%b payload=%h, expected 1 and %h", rsp_valid, {rsp_result, rsp_status, rsp_tag}, held);
        end
        checks++;
        if (fma_out_ready !== 1'b0) begin errors++; $display("FAIL bp_out_ready: got %b, expected 0", fma_out_ready); end
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (!rsp_fire) begin errors++; $display("FAIL bp_stream: no response in release cycle %0d", i); end
        end
        step();
        checks++;
        if (n_rsp - b_rsp != 3) begin errors++; $display("FAIL bp_count: got %0d responses, expected 3", n_rsp - b_rsp); end
    endtask

    task automatic test_flush();
        int b_iss, b_out;
        fma_ready = 1'b1; release_cnt = 0; rsp_ready = 1'b1;
        b_iss = n_iss; b_out = n_out;
        send_req(2'd0, 16'h1000, 16'h2000, 16'h3000, 1'b0, 4'd6);
        send_req(2'd3, 16'h1100, 16'h2200, 16'h3300, 1'b0, 4'd7);
        wait_issues(b_iss + 2);
        fma_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_req(2'd2, 16'(i), 16'(i + 1), 16'(i + 2), 1'b0, 4'(10 + i));
        flush = 1'b1;
        step();
        flush = 1'b0;
        exp_iss.delete();
        exp_rsp.delete();
        checks++;
        if ({fma_flush, req_ready, fma_valid, busy} !== 4'b1001) begin
            errors++; $display("FAIL flush_pulse: flush/ready/valid/busy=%b, expected 1001", {fma_flush, req_ready, fma_valid, busy});
        end
        fma_ready = 1'b1;
        step();
        checks++;
        if (fma_flush !== 1'b0) begin errors++; $display("FAIL flush_one_cycle: fma_flush=%b, expected 0", fma_flush); end
        release_cnt = 2;
        wait_out(b_out + 2);
        checks++;
        if ({busy, req_ready, rsp_valid} !== 3'b010) begin
            errors++; $display("FAIL flush_drained: busy/ready/rsp_valid=%b, expected 010", {busy, req_ready, rsp_valid});
        end
        repeat (3) step();
        checks++;
        if (n_iss - b_iss != 2) begin errors++; $display("FAIL flush_no_issue: got %0d issues, expected 2", n_iss - b_iss); end
    endtask

    task automatic test_reset_mid();
        int b_iss;
        fma_ready = 1'b1; release_cnt = 0; b_iss = n_iss;
        send_req(2'd0, 16'h0aaa, 16'h0bbb, 16'h0ccc, 1'b0, 4'd1);
        send_req(2'd1, 16'h0ddd, 16'h0eee, 16'h0fff, 1'b1, 4'd2);
        wait_issues(b_iss + 2);
        fma_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_req(2'd3, 16'(i + 5), 16'(i + 6), 16'(i + 7), 1'b0, 4'(i));
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({fma_valid, fma_flush, rsp_valid, busy, fma_out_ready, req_ready} !== 6'b000011) begin
            errors++; $display("FAIL midreset_ctl: got %b, expected 000011",
                               {fma_valid, fma_flush, rsp_valid, busy, fma_out_ready, req_ready});
        end
        checks++;
        if ({fma_operands, fma_op, fma_op_mod, fma_tag, rsp_result, rsp_status, rsp_tag} !== '0) begin
            errors++; $display("FAIL midreset_payload: got %h, expected 0",
                               {fma_operands, fma_op, fma_op_mod, fma_tag, rsp_result, rsp_status, rsp_tag});
        end
        exp_iss.delete(); exp_rsp.delete(); model_q.delete(); fma_out_valid = 1'b0;
        step(); step();
        checks++;
        if ({fma_flush, busy} !== 2'b00) begin errors++; $display("FAIL midreset_noflush: flush/busy=%b, expected 00", {fma_flush, busy}); end
        rst = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_outstanding();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
